// File: rtl/alu_issue_if.sv
// Instruction issue channel into alu_issue.
// Handshake: an instruction transfers on a rising clk edge where
// instr_valid && instr_ready are both high; fields are sampled only on that
// edge, and instr_valid held high while instr_ready is low has no effect.
interface alu_issue_if #(
  parameter int ADDR_W = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback sequencer around an external combinational ALU.
// Holds a small register file, latches operands on instruction acceptance,
// lets the ALU settle for one EXEC cycle, then writes the result back and
// updates result/carry/zero flags with a one-cycle done pulse.
module alu_issue #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_if.slave        instr,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_cout,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry_flag,
  output logic              zero_flag,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_sel_q, alu_sel_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              accept;

  // Ready only in IDLE and never while reset is asserted.
  assign instr.instr_ready = (state_q == ST_IDLE) && !rst;
  assign accept            = instr.instr_valid && instr.instr_ready;

  // Next-state, operand latch, load port and writeback.
  always_comb begin
    state_d   = state_q;
    rf_d      = rf_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;

    // Load first so a same-edge writeback to the same address overrides it.
    if (ld_valid) begin
      rf_d[ld_addr] = ld_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Operands come from rf_q: a same-edge load is not bypassed.
          alu_a_d   = rf_q[instr.instr_rs1];
          alu_b_d   = rf_q[instr.instr_rs2];
          alu_sel_d = instr.instr_op;
          rd_d      = instr.instr_rd;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rf_d[rd_q] = alu_y;
        result_d   = alu_y;
        carry_d    = alu_cout;
        zero_d     = (alu_y == '0);
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any EXEC in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rf_q      <= rf_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign done       = done_q;
  assign result     = result_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural 4-bit ALU, a reference
// register-file model and an expected-writeback queue.
module tb_alu_issue;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if #(.ADDR_W(ADDR_W)) ifc ();

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] alu_a, alu_b, alu_y;
  logic [2:0]        alu_sel;
  logic              alu_cout;
  logic              done, carry_flag, zero_flag;
  logic [DATA_W-1:0] result, dbg_data;
  logic [ADDR_W-1:0] dbg_addr;

  alu_issue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (ifc),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_y      (alu_y),
    .alu_cout   (alu_cout),
    .done       (done),
    .result     (result),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Behavioural ALU: {carry_out, Y}.
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel);
    case (sel)
      3'b000:  alu_fn = {1'b0, a} + {1'b0, b};
      3'b001:  alu_fn = {1'b0, a} - {1'b0, b};
      3'b010:  alu_fn = {1'b0, a & b};
      3'b011:  alu_fn = {1'b0, a | b};
      3'b100:  alu_fn = {1'b0, a ^ b};
      3'b101:  alu_fn = {1'b0, ~a};
      3'b110:  alu_fn = {1'b0, a} + 5'd1;
      default: alu_fn = {1'b0, a} - 5'd1;
    endcase
  endfunction

  logic [4:0] alu_out;
  assign alu_out  = alu_fn(alu_a, alu_b, alu_sel);
  assign alu_y    = alu_out[3:0];
  assign alu_cout = alu_out[4];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W+1:0] exp_q[$];        // {carry, zero, result}
  logic [DATA_W-1:0] mrf [1 << ADDR_W];
  logic started = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every done pulse must match the oldest expected writeback.
  always @(negedge clk) begin
    if (started && done !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {7'd0, done}, 8'd0);
      end else begin
        logic [DATA_W+1:0] e;
        e = exp_q.pop_front();
        check("wb_result", {4'd0, result}, {4'd0, e[3:0]});
        check("wb_zero", {7'd0, zero_flag}, {7'd0, e[4]});
        check("wb_carry", {7'd0, carry_flag}, {7'd0, e[5]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2);
    logic [4:0] r;
    r = alu_fn(mrf[rs1], mrf[rs2], op);
    exp_q.push_back({r[4], (r[3:0] == 4'd0), r[3:0]});
    mrf[rd] = r[3:0];
  endtask

  task automatic load(input logic [1:0] addr, input logic [3:0] data);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    @(negedge clk);
    ld_valid = 1'b0;
    mrf[addr] = data;
  endtask

  // Present an instruction, wait (bounded) for acceptance; returns at the
  // negedge inside EXEC.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2,
                       input bit keep_valid);
    bit ok;
    ok = 1'b0;
    ifc.instr_valid = 1'b1;
    ifc.instr_op    = op;
    ifc.instr_rd    = rd;
    ifc.instr_rs1   = rs1;
    ifc.instr_rs2   = rs2;
    for (int i = 0; i < 8; i++) begin
      if (ifc.instr_ready === 1'b1) begin
        push_exp(op, rd, rs1, rs2);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!keep_valid) ifc.instr_valid = 1'b0;
    check("issue_accepted", {7'd0, ok}, 8'd1);
  endtask

  task automatic read_reg(input string tag, input logic [1:0] addr, input logic [3:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, {4'd0, dbg_data}, {4'd0, exp});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ifc.instr_valid = 1'b0;
    ifc.instr_op    = '0;
    ifc.instr_rd    = '0;
    ifc.instr_rs1   = '0;
    ifc.instr_rs2   = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    dbg_addr = '0;
    for (int i = 0; i < 4; i++) mrf[i] = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    started = 1'b1;
    check("ready_in_reset", {7'd0, ifc.instr_ready}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {7'd0, ifc.instr_ready}, 8'd1);
    check("done_after_reset", {7'd0, done}, 8'd0);
    check("result_after_reset", {4'd0, result}, 8'd0);
    check("flags_after_reset", {6'd0, carry_flag, zero_flag}, 8'd0);
    for (int i = 0; i < 4; i++) read_reg("rf_after_reset", 2'(i), 4'd0);

    // Add: 0011 + 0101
    load(2'd0, 4'b0011);
    load(2'd1, 4'b0101);
    issue(3'b000, 2'd2, 2'd0, 2'd1, 1'b0);
    check("add_exec_a", {4'd0, alu_a}, 8'h03);
    check("add_exec_b", {4'd0, alu_b}, 8'h05);
    check("add_exec_sel", {5'd0, alu_sel}, 8'h00);
    check("add_exec_ready", {7'd0, ifc.instr_ready}, 8'd0);
    check("add_exec_no_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    check("add_done", {7'd0, done}, 8'd1);
    check("add_result", {4'd0, result}, 8'h08);
    check("add_flags", {6'd0, carry_flag, zero_flag}, 8'd0);
    read_reg("add_r2", 2'd2, 4'b1000);
    @(negedge clk);
    check("add_done_one_cycle", {7'd0, done}, 8'd0);

    // Subtract: 1000 - 0011, two edges from acceptance to done
    load(2'd0, 4'b1000);
    load(2'd1, 4'b0011);
    issue(3'b001, 2'd3, 2'd0, 2'd1, 1'b0);
    check("sub_no_done_exec", {7'd0, done}, 8'd0);
    @(negedge clk);
    check("sub_done", {7'd0, done}, 8'd1);
    check("sub_result", {4'd0, result}, 8'h05);
    read_reg("sub_r3", 2'd3, 4'b0101);
    @(negedge clk);

    // Wrap-around: 1111 + 0001 -> 0000, carry, zero
    load(2'd0, 4'b1111);
    load(2'd1, 4'b0001);
    issue(3'b000, 2'd0, 2'd0, 2'd1, 1'b0);
    @(negedge clk);
    check("wrap_result", {4'd0, result}, 8'h00);
    check("wrap_carry", {7'd0, carry_flag}, 8'd1);
    check("wrap_zero", {7'd0, zero_flag}, 8'd1);
    read_reg("wrap_r0", 2'd0, 4'd0);
    @(negedge clk);

    // Back-to-back with dependency, instr_valid held high
    load(2'd0, 4'd1);
    load(2'd1, 4'd6);
    issue(3'b000, 2'd2, 2'd0, 2'd1, 1'b1);
    check("b2b_ready_exec", {7'd0, ifc.instr_ready}, 8'd0);
    ifc.instr_op  = 3'b100;
    ifc.instr_rd  = 2'd3;
    ifc.instr_rs1 = 2'd2;
    ifc.instr_rs2 = 2'd1;
    @(negedge clk);
    check("b2b_ready_done", {7'd0, ifc.instr_ready}, 8'd1);
    check("b2b_done1", {7'd0, done}, 8'd1);
    check("b2b_result1", {4'd0, result}, 8'h07);
    push_exp(3'b100, 2'd3, 2'd2, 2'd1);
    @(negedge clk);
    ifc.instr_valid = 1'b0;
    check("b2b_ready_exec2", {7'd0, ifc.instr_ready}, 8'd0);
    check("b2b_gap", {7'd0, done}, 8'd0);
    check("b2b_exec2_a", {4'd0, alu_a}, 8'h07);
    @(negedge clk);
    check("b2b_done2", {7'd0, done}, 8'd1);
    check("b2b_result2", {4'd0, result}, 8'h01);
    read_reg("b2b_r3", 2'd3, 4'd1);
    @(negedge clk);

    // Same-edge load to a source register is not bypassed
    load(2'd0, 4'd2);
    load(2'd1, 4'd4);
    ld_valid = 1'b1;
    ld_addr  = 2'd0;
    ld_data  = 4'd9;
    issue(3'b000, 2'd3, 2'd0, 2'd1, 1'b0);
    ld_valid = 1'b0;
    mrf[0] = 4'd9;
    check("nobypass_a", {4'd0, alu_a}, 8'h02);
    @(negedge clk);
    check("nobypass_result", {4'd0, result}, 8'h06);
    read_reg("nobypass_r0", 2'd0, 4'd9);
    @(negedge clk);

    // Load/writeback collision, plus a different-address load on that edge
    issue(3'b000, 2'd2, 2'd1, 2'd1, 1'b0);
    ld_valid = 1'b1;
    ld_addr  = 2'd2;
    ld_data  = 4'b1010;
    @(negedge clk);
    ld_valid = 1'b0;
    read_reg("collision_r2", 2'd2, 4'd8);
    issue(3'b110, 2'd3, 2'd1, 2'd1, 1'b0);
    ld_valid = 1'b1;
    ld_addr  = 2'd0;
    ld_data  = 4'b1100;
    @(negedge clk);
    ld_valid = 1'b0;
    mrf[0] = 4'b1100;
    read_reg("parallel_r3", 2'd3, 4'd5);
    read_reg("parallel_r0", 2'd0, 4'b1100);
    @(negedge clk);

    // Reset mid-EXEC: no writeback, no done, everything cleared
    issue(3'b000, 2'd1, 2'd0, 2'd0, 1'b0);
    rst = 1'b1;
    void'(exp_q.pop_back());
    for (int i = 0; i < 4; i++) mrf[i] = '0;
    @(negedge clk);
    check("rst_no_done", {7'd0, done}, 8'd0);
    check("rst_ready", {7'd0, ifc.instr_ready}, 8'd0);
    check("rst_result", {4'd0, result}, 8'd0);
    check("rst_flags", {6'd0, carry_flag, zero_flag}, 8'd0);
    for (int i = 0; i < 4; i++) read_reg("rst_rf", 2'(i), 4'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_after", {7'd0, ifc.instr_ready}, 8'd1);
    check("rst_done_after", {7'd0, done}, 8'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
